// File: rtl/pwm_sample_sequencer.sv
// Sample scheduler for pwm_audio: buffers producer samples and hands over exactly one per PWM frame,
// holding and counting on underrun, and ramping one code per frame toward midscale while muted.
module pwm_sample_sequencer #(
    parameter int PERIOD = 255,
    parameter int DEPTH  = 4,
    parameter int MID    = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    input  logic                       mute,
    output logic [7:0]                 sample_out,
    output logic                       frame_start,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [15:0]                underrun_cnt
);
    // state | meaning
    // IDLE  | stopped: frame counter at 0, FIFO empty, output parked at MID
    // RUN   | pop one sample per frame boundary; a starved boundary holds and counts
    // MUTE  | step output one code toward MID per boundary; queued samples are dropped

    localparam int             CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             LW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
    localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);
    localparam logic [7:0]     MID_CODE = 8'(MID);

    typedef enum logic [1:0] {IDLE, RUN, MUTE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [7:0]    sample_q;
    logic          frame_start_q;
    logic [15:0]   underrun_q;

    logic boundary;
    logic push;
    logic pop;

    assign in_ready = (state_q != IDLE) && (level_q < LVL_FULL);
    assign push     = in_valid && in_ready;
    assign boundary = (state_q != IDLE) && (cnt_q == CNT_LAST);
    // Pop decision uses the registered level, so a push landing on the boundary cannot satisfy it.
    assign pop      = boundary && (level_q != '0);

    assign sample_out   = sample_q;
    assign frame_start  = frame_start_q;
    assign fifo_level   = level_q;
    assign underrun_cnt = underrun_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable) state_d = mute ? MUTE : RUN;
            RUN: begin
                if (!enable)   state_d = IDLE;
                else if (mute) state_d = MUTE;
            end
            MUTE: begin
                if (!enable)    state_d = IDLE;
                else if (!mute) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            sample_q      <= MID_CODE;
            frame_start_q <= 1'b0;
            underrun_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE || !enable) begin
                // Abrupt stop: flush and park; underrun history survives until rst.
                cnt_q         <= '0;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                level_q       <= '0;
                sample_q      <= MID_CODE;
                frame_start_q <= 1'b0;
            end else begin
                frame_start_q <= boundary;
                cnt_q         <= boundary ? '0 : cnt_q + 1'b1;
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      level_q <= level_q + 1'b1;
                else if (!push && pop) level_q <= level_q - 1'b1;
                if (boundary) begin
                    if (state_q == MUTE) begin
                        if (sample_q < MID_CODE)      sample_q <= sample_q + 1'b1;
                        else if (sample_q > MID_CODE) sample_q <= sample_q - 1'b1;
                    end else if (pop) begin
                        sample_q <= mem[rd_ptr_q];
                    end else if (underrun_q != 16'hFFFF) begin
                        underrun_q <= underrun_q + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Self-checking bench for pwm_sample_sequencer: directed frame scenarios plus a randomized
// queue-based reference model; ph counts negedges since the one that drove enable high.
module tb_pwm_sample_sequencer;
    localparam int         PERIOD = 255;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] MID    = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mute;
    logic [7:0]  sample_out;
    logic        frame_start;
    logic [2:0]  fifo_level;
    logic [15:0] underrun_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ph      = 0;
    logic [15:0] exp_und = '0;

    pwm_sample_sequencer #(.PERIOD(PERIOD), .DEPTH(DEPTH), .MID(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mute         (mute),
        .sample_out   (sample_out),
        .frame_start  (frame_start),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        ph++;
    endtask

    task automatic start_run();
        enable   = 1'b1;
        mute     = 1'b0;
        in_valid = 1'b0;
        ph       = 0;
    endtask

    task automatic stop_run();
        enable   = 1'b0;
        mute     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Output expected after k muted boundaries starting from s0.
    function automatic logic [7:0] ramp(input logic [7:0] s0, input int k);
        int d;
        d = int'(s0) - int'(MID);
        if (d > 0) return 8'(int'(s0) - ((k < d) ? k : d));
        else       return 8'(int'(s0) + ((k < -d) ? k : -d));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enable   = 1'($urandom);
            in_valid = 1'($urandom);
            mute     = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        n_tests++; if (sample_out !== MID) begin n_fail++; $display("FAIL rst_sample: got %02h want %02h", sample_out, MID); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", in_ready); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        n_tests++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_underrun: got %0d want 0", underrun_cnt); end
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: got %0b want 0", frame_start); end
        rst = 1'b0; enable = 1'b0; in_valid = 1'b0; mute = 1'b0;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b0 || sample_out !== MID) begin
            n_fail++; $display("FAIL idle_after_rst: got ready=%0b sample=%02h want ready=0 sample=%02h", in_ready, sample_out, MID);
        end
        exp_und = '0;
    endtask

    task automatic test_stream();
        logic [7:0] s [3];
        logic [7:0] q [$];
        logic [7:0] last;
        logic       fs_exp;
        s[0] = 8'h10; s[1] = 8'h20; s[2] = 8'h30;
        start_run();
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready ph=%0d: got %0b want 1", ph, in_ready); end
            in_valid = 1'b1; in_data = s[i]; q.push_back(s[i]);
        end
        step(); in_valid = 1'b0;
        n_tests++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL stream_level: got %0d want 3", fifo_level); end
        last = MID;
        while (ph < 3*PERIOD + 1) begin
            step();
            fs_exp = (ph % PERIOD == 1) && (ph > 1);
            n_tests++; if (frame_start !== fs_exp) begin n_fail++; $display("FAIL stream_frame_start ph=%0d: got %0b want %0b", ph, frame_start, fs_exp); end
            if (fs_exp) last = q.pop_front();
            n_tests++; if (sample_out !== last) begin n_fail++; $display("FAIL stream_sample ph=%0d: got %02h want %02h", ph, sample_out, last); end
        end
        n_tests++; if (fifo_level !== 3'd0 || underrun_cnt !== exp_und) begin
            n_fail++; $display("FAIL stream_end: got level=%0d und=%0d want level=0 und=%0d", fifo_level, underrun_cnt, exp_und);
        end
        stop_run();
    endtask

    task automatic test_underrun();
        logic [7:0] v;
        logic [7:0] exp_s;
        logic       fs_exp;
        v = 8'($urandom);
        start_run();
        step(); in_valid = 1'b1; in_data = v;
        step(); in_valid = 1'b0;
        while (ph < 3*PERIOD + 1) begin
            step();
            fs_exp = (ph % PERIOD == 1) && (ph > 1);
            exp_s  = (ph > PERIOD) ? v : MID;
            n_tests++; if (frame_start !== fs_exp) begin n_fail++; $display("FAIL und_frame_start ph=%0d: got %0b want %0b", ph, frame_start, fs_exp); end
            n_tests++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL und_sample ph=%0d: got %02h want %02h", ph, sample_out, exp_s); end
            if (fs_exp) begin
                if (ph > PERIOD + 1 && exp_und != 16'hFFFF) exp_und = exp_und + 16'd1;
                n_tests++; if (underrun_cnt !== exp_und) begin n_fail++; $display("FAIL und_count ph=%0d: got %0d want %0d", ph, underrun_cnt, exp_und); end
            end
        end
        stop_run();
    endtask

    task automatic test_backpressure();
        logic [7:0] q [$];
        logic [7:0] d;
        logic [7:0] last;
        logic       fs_exp;
        logic       rdy_exp;
        int         acc;
        acc = 0;
        start_run();
        for (int i = 0; i < 6; i++) begin
            step();
            rdy_exp = (acc < DEPTH);
            n_tests++; if (in_ready !== rdy_exp) begin n_fail++; $display("FAIL bp_ready ph=%0d: got %0b want %0b", ph, in_ready, rdy_exp); end
            d = 8'($urandom); in_valid = 1'b1; in_data = d;
            if (rdy_exp) begin q.push_back(d); acc++; end
        end
        step(); in_valid = 1'b0;
        n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level_full: got %0d want 4", fifo_level); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %0b want 0", in_ready); end
        last = MID;
        while (ph < 5*PERIOD + 1) begin
            step();
            fs_exp = (ph % PERIOD == 1) && (ph > 1);
            n_tests++; if (frame_start !== fs_exp) begin n_fail++; $display("FAIL bp_frame_start ph=%0d: got %0b want %0b", ph, frame_start, fs_exp); end
            if (fs_exp) last = q.pop_front();
            n_tests++; if (sample_out !== last) begin n_fail++; $display("FAIL bp_sample ph=%0d: got %02h want %02h", ph, sample_out, last); end
            if (ph == PERIOD) begin
                n_tests++; if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin
                    n_fail++; $display("FAIL bp_no_bypass: got ready=%0b level=%0d want ready=0 level=4", in_ready, fifo_level);
                end
            end
            if (ph == 2*PERIOD) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_boundary_ready: got %0b want 1", in_ready); end
                d = 8'($urandom); in_valid = 1'b1; in_data = d; q.push_back(d);
            end
            if (ph == 2*PERIOD + 1) begin
                in_valid = 1'b0;
                n_tests++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL bp_push_pop_level: got %0d want 3", fifo_level); end
            end
        end
        stop_run();
    endtask

    task automatic test_mute();
        logic [7:0] s0;
        logic [7:0] r;
        logic [7:0] exp_s;
        int         k;
        int         lvl_exp;
        for (int it = 0; it < 2; it++) begin
            s0 = (it == 0) ? 8'h84 : 8'($urandom_range(32'h7B, 32'h7F));
            r  = 8'($urandom);
            start_run();
            for (int i = 0; i < 4; i++) begin
                step(); in_valid = 1'b1; in_data = (i == 0) ? s0 : 8'($urandom);
            end
            step(); in_valid = 1'b0;
            while (ph < 7*PERIOD + 1) begin
                step();
                k = (ph - 1) / PERIOD - 1;
                if (ph <= PERIOD)  exp_s = MID;
                else if (k == 0)   exp_s = s0;
                else if (k <= 5)   exp_s = ramp(s0, k);
                else               exp_s = r;
                n_tests++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL mute_sample it=%0d ph=%0d: got %02h want %02h", it, ph, sample_out, exp_s); end
                if ((ph % PERIOD == 1) && (ph > 1)) begin
                    lvl_exp = (k >= 3) ? 0 : 3 - k;
                    n_tests++; if (fifo_level !== 3'(lvl_exp)) begin n_fail++; $display("FAIL mute_level ph=%0d: got %0d want %0d", ph, fifo_level, lvl_exp); end
                    n_tests++; if (underrun_cnt !== exp_und) begin n_fail++; $display("FAIL mute_underrun ph=%0d: got %0d want %0d", ph, underrun_cnt, exp_und); end
                end
                if (ph == PERIOD + 5)     mute = 1'b1;
                if (ph == 6*PERIOD + 1)   mute = 1'b0;
                if (ph == 6*PERIOD + 2)   begin in_valid = 1'b1; in_data = r; end
                if (ph == 6*PERIOD + 3)   in_valid = 1'b0;
            end
            stop_run();
        end
    endtask

    task automatic test_disable();
        logic [7:0] d0;
        logic [7:0] d2;
        logic [7:0] exp_s;
        d0 = 8'($urandom);
        d2 = 8'($urandom);
        start_run();
        step(); in_valid = 1'b1; in_data = d0;
        step(); in_data = 8'($urandom);
        step(); in_valid = 1'b0;
        while (ph < PERIOD + 101) begin
            step();
            exp_s = (ph > PERIOD) ? d0 : MID;
            n_tests++; if (frame_start !== (ph == PERIOD + 1)) begin n_fail++; $display("FAIL dis_frame_start ph=%0d: got %0b", ph, frame_start); end
            n_tests++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL dis_sample ph=%0d: got %02h want %02h", ph, sample_out, exp_s); end
        end
        n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL dis_level_before: got %0d want 1", fifo_level); end
        enable = 1'b0;
        step();
        n_tests++; if (sample_out !== MID) begin n_fail++; $display("FAIL dis_sample_mid: got %02h want %02h", sample_out, MID); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL dis_level_flush: got %0d want 0", fifo_level); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready: got %0b want 0", in_ready); end
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL dis_frame_start_off: got %0b want 0", frame_start); end
        n_tests++; if (underrun_cnt !== exp_und) begin n_fail++; $display("FAIL dis_underrun_kept: got %0d want %0d", underrun_cnt, exp_und); end
        step(); step(); step();
        start_run();
        step();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reen_ready: got %0b want 1", in_ready); end
        in_valid = 1'b1; in_data = d2;
        step(); in_valid = 1'b0;
        while (ph < PERIOD + 1) begin
            step();
            exp_s = (ph == PERIOD + 1) ? d2 : MID;
            n_tests++; if (frame_start !== (ph == PERIOD + 1)) begin n_fail++; $display("FAIL reen_frame_start ph=%0d: got %0b", ph, frame_start); end
            n_tests++; if (sample_out !== exp_s) begin n_fail++; $display("FAIL reen_sample ph=%0d: got %02h want %02h", ph, sample_out, exp_s); end
        end
        n_tests++; if (underrun_cnt !== exp_und) begin n_fail++; $display("FAIL reen_underrun: got %0d want %0d", underrun_cnt, exp_und); end
        stop_run();
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] msample;
        logic [7:0] d;
        logic       v;
        logic       fs_exp;
        logic       room;
        int         rate;
        msample = MID;
        rate    = $urandom_range(0, 2);
        start_run();
        while (ph < 8*PERIOD + 1) begin
            step();
            fs_exp = (ph % PERIOD == 1) && (ph > 1);
            n_tests++; if (frame_start !== fs_exp) begin n_fail++; $display("FAIL rnd_frame_start ph=%0d: got %0b want %0b", ph, frame_start, fs_exp); end
            n_tests++; if (sample_out !== msample) begin n_fail++; $display("FAIL rnd_sample ph=%0d: got %02h want %02h", ph, sample_out, msample); end
            n_tests++; if (fifo_level !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_level ph=%0d: got %0d want %0d", ph, fifo_level, q.size()); end
            n_tests++; if (in_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready ph=%0d: got %0b", ph, in_ready); end
            n_tests++; if (underrun_cnt !== exp_und) begin n_fail++; $display("FAIL rnd_underrun ph=%0d: got %0d want %0d", ph, underrun_cnt, exp_und); end
            if (ph % PERIOD == 1) rate = $urandom_range(0, 2);
            v = (rate == 2) || (rate == 1 && $urandom_range(0, 99) == 0);
            d = 8'($urandom);
            in_valid = v; in_data = d;
            room = (q.size() < DEPTH);
            if (ph % PERIOD == 0) begin
                if (q.size() > 0) msample = q.pop_front();
                else if (exp_und != 16'hFFFF) exp_und = exp_und + 16'd1;
            end
            if (v && room) q.push_back(d);
        end
        stop_run();
    endtask

    task automatic test_reset_midrun();
        logic [7:0] d;
        int         n;
        d = 8'($urandom);
        n = $urandom_range(2*PERIOD + 10, 2*PERIOD + 190);
        start_run();
        step(); in_valid = 1'b1; in_data = d;
        step(); in_valid = 1'b0;
        while (ph < n) step();
        if (exp_und != 16'hFFFF) exp_und = exp_und + 16'd1;
        n_tests++; if (underrun_cnt !== exp_und || sample_out !== d) begin
            n_fail++; $display("FAIL mid_pre: got und=%0d sample=%02h want und=%0d sample=%02h", underrun_cnt, sample_out, exp_und, d);
        end
        rst = 1'b1;
        step();
        n_tests++; if (sample_out !== MID) begin n_fail++; $display("FAIL mid_rst_sample: got %02h want %02h", sample_out, MID); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
        n_tests++; if (underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_underrun: got %0d want 0", underrun_cnt); end
        n_tests++; if (in_ready !== 1'b0 || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ctrl: got ready=%0b fs=%0b want 0 0", in_ready, frame_start);
        end
        rst = 1'b0; enable = 1'b0;
        exp_und = '0;
        step();
        n_tests++; if (in_ready !== 1'b0 || sample_out !== MID) begin
            n_fail++; $display("FAIL mid_idle: got ready=%0b sample=%02h", in_ready, sample_out);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; mute = 1'b0; in_data = 8'h00;
        test_reset();
        test_stream();
        test_underrun();
        test_backpressure();
        test_mute();
        test_disable();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at ph=%0d", ph);
        $fatal(1, "watchdog");
    end
endmodule
